pixel_sink_writer: RTL and testbench

Receives the (x, y, colour) pixel stream produced by the screen drawers and commits it into a 160x120, 3-bit frame RAM. It converts coordinates to a linear address, drops out-of-bounds pixels, and tracks raster progress so the controller knows when a full frame has landed. It sits between the drawers and the frame RAM write port, and absorbs RAM back-pressure through a 2-stage valid/ready pipeline.

---
 rtl/pixel_sink_writer.sv | 144 ++++++++++++++
 tb/tb_pixel_sink_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sink_writer.sv
// pixel_sink_writer: commits a drawer's (x, y, colour) stream into a WIDTHxHEIGHT frame RAM
// through a 2-stage valid/ready pipeline. Define PIXSINK_CHECKSUM_EN to build the frame checksum.
module pixel_sink_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15,
    parameter int COL_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [COL_W-1:0]  in_col,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [COL_W-1:0]  ram_data,
    output logic              ram_wren,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] pix_count,
    output logic              frame_done,
    output logic              oob_err,
    output logic              seq_err,
    output logic [15:0]       checksum,
    output logic [1:0]        dbg_state
);
    // Handshakes: a pixel transfers on a rising edge with in_valid && in_ready, and a RAM write
    // commits on a rising edge with ram_wren && ram_ready; while waiting, the offering side holds
    // its payload stable and the accepting side may change its ready freely.

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] FULL  = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [15:0]       W_LIM = 16'(WIDTH);
    localparam logic [15:0]       H_LIM = 16'(HEIGHT);

    state_t            state;
    logic              s1_valid;
    logic [7:0]        s1_x;
    logic [6:0]        s1_y;
    logic [COL_W-1:0]  s1_col;
    logic              s2_valid;
    logic              s2_oob;
    logic [ADDR_W-1:0] s2_addr;
    logic [COL_W-1:0]  s2_col;
    logic [ADDR_W-1:0] expected_addr;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_oob;
    logic              adv1;
    logic              adv2;
    logic              accept;
    logic              commit;

    // Out-of-bounds entries never wait on the RAM, so they cannot stall the pipeline.
    assign adv2      = !s2_valid || ram_ready || s2_oob;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = reset_n && adv1 && (state != DONE) && !frame_start;
    assign accept    = in_valid && in_ready;
    assign ram_wren  = s2_valid && !s2_oob;
    assign ram_addr  = s2_addr;
    assign ram_data  = s2_col;
    assign commit    = ram_wren && ram_ready;
    assign dbg_state = state;

    always_comb begin
        if (WIDTH == 160)
            s1_addr = (ADDR_W'(s1_y) << 7) + (ADDR_W'(s1_y) << 5) + ADDR_W'(s1_x);
        else
            s1_addr = ADDR_W'(s1_y) * ADDR_W'(WIDTH) + ADDR_W'(s1_x);
        s1_oob = !((16'(s1_x) < W_LIM) && (16'(s1_y) < H_LIM));
    end

    always_ff @(posedge clock) begin
        if (!reset_n || frame_start) begin
            state         <= IDLE;
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            s1_col        <= '0;
            s2_valid      <= 1'b0;
            s2_oob        <= 1'b0;
            s2_addr       <= '0;
            s2_col        <= '0;
            expected_addr <= '0;
            pix_count     <= '0;
            frame_done    <= 1'b0;
            oob_err       <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_x   <= in_x;
                    s1_y   <= in_y;
                    s1_col <= in_col;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_addr <= s1_addr;
                    s2_col  <= s1_col;
                    s2_oob  <= s1_oob;
                end
            end
            if (s2_valid && s2_oob)
                oob_err <= 1'b1;
            if (commit) begin
                expected_addr <= expected_addr + 1'b1;
                if (pix_count != FULL)
                    pix_count <= pix_count + 1'b1;
                if (s2_addr != expected_addr)
                    seq_err <= 1'b1;
            end
            case (state)
                IDLE:    if (accept) state <= CAPTURE;
                CAPTURE: begin
                    if (commit && s2_addr == LAST && pix_count == LAST) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIXSINK_CHECKSUM_EN
    logic [15:0] cs_q;
    always_ff @(posedge clock) begin
        if (!reset_n || frame_start)
            cs_q <= '0;
        else if (commit)
            cs_q <= {cs_q[14:0], cs_q[15]} ^ 16'(ram_data);
    end
    assign checksum = cs_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_sink_writer.sv
// Self-checking bench for pixel_sink_writer: vector table, hand sequences for stalls and
// frame_start, and randomized traffic against a queue-based write model.
`timescale 1ns/1ps
module tb_pixel_sink_writer;
    localparam int W = 160;
    localparam int H = 120;
    localparam int NPIX = W * H;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_col = '0;
    logic [14:0] ram_addr;
    logic [2:0]  ram_data;
    logic        ram_wren;
    logic        ram_ready = 1'b1;
    logic [14:0] pix_count;
    logic        frame_done;
    logic        oob_err;
    logic        seq_err;
    logic [15:0] checksum;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    bit rand_ready = 1'b0;

    // Behavioural model: expected RAM writes in order, plus frame-level counters.
    logic [17:0] exp_q[$];
    int          mdl_count, mdl_commits;
    bit          mdl_oob, mdl_seq, mdl_done;
    logic [15:0] mdl_cs;
    bit          stall_prev = 1'b0;
    logic [17:0] stall_word;

    typedef struct {
        int x, y, col;
        bit exp_wren;
        int exp_addr, exp_count;
        bit exp_oob, exp_seq;
        logic [15:0] exp_cs;
    } vec_t;
    vec_t vecs[6];

    pixel_sink_writer dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_col(in_col),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_ready(ram_ready),
        .pix_count(pix_count), .frame_done(frame_done), .oob_err(oob_err), .seq_err(seq_err),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (rand_ready) ram_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n || frame_start) begin
            exp_q.delete();
            mdl_count = 0; mdl_commits = 0;
            mdl_oob = 0; mdl_seq = 0; mdl_done = 0; mdl_cs = '0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("stall_stable", {13'd0, ram_wren, ram_addr, ram_data}, {13'd0, 1'b1, stall_word});
            stall_prev = ram_wren && !ram_ready;
            stall_word = {ram_addr, ram_data};
            if (ram_wren && ram_ready) begin
                logic [17:0] w;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {14'd0, ram_addr, ram_data}, 32'hFFFF_FFFF);
                    w = {ram_addr, ram_data};
                end else begin
                    w = exp_q.pop_front();
                    chk("commit", {14'd0, ram_addr, ram_data}, {14'd0, w});
                end
                if (int'(w[17:3]) != mdl_commits) mdl_seq = 1;
                if (int'(w[17:3]) == NPIX - 1 && mdl_count == NPIX - 1) mdl_done = 1;
                if (mdl_count < NPIX) mdl_count++;
                mdl_commits++;
                mdl_cs = {mdl_cs[14:0], mdl_cs[15]} ^ {13'd0, w[2:0]};
            end
            if (in_valid && in_ready) begin
                if (in_x < W && in_y < H) exp_q.push_back({15'(int'(in_y) * W + int'(in_x)), in_col});
                else mdl_oob = 1;
            end
        end
    end

    task automatic send(input int x, input int y, input int c, output int waits);
        int t;
        in_x = 8'(x); in_y = 7'(y); in_col = 3'(c); in_valid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clock);
        end
        waits = t;
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", t);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        in_valid = 1'b0;
        ram_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] cs_exp;
`ifdef PIXSINK_CHECKSUM_EN
        cs_exp = mdl_cs;
`else
        cs_exp = 16'h0000;
`endif
        chk({tag, "_pix_count"}, 32'(pix_count), 32'(mdl_count));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(mdl_done));
        chk({tag, "_oob_err"}, 32'(oob_err), 32'(mdl_oob));
        chk({tag, "_seq_err"}, 32'(seq_err), 32'(mdl_seq));
        chk({tag, "_checksum"}, 32'(checksum), 32'(cs_exp));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int waits, total_waits;
        logic [15:0] cs_exp;

        vecs[0] = '{160, 0,   5, 1'b0, 0,     0, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{0,   120, 3, 1'b0, 0,     0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{0,   0,   1, 1'b1, 0,     1, 1'b1, 1'b0, 16'h0001};
        vecs[3] = '{1,   0,   2, 1'b1, 1,     2, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{3,   0,   7, 1'b1, 3,     3, 1'b1, 1'b1, 16'h0007};
        vecs[5] = '{159, 119, 4, 1'b1, 19199, 4, 1'b1, 1'b1, 16'h000A};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_outputs", {ram_wren, ram_addr, ram_data, frame_done, oob_err, seq_err},
            '0);
        chk("reset_counters", {pix_count, checksum}, '0);
        reset_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);

        // Vector table: single pixels with full latency and cumulative flag checks.
        pulse_frame_start();
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].col, waits);
            @(posedge clock); #1;
            chk($sformatf("vec%0d_wren", i), 32'(ram_wren), 32'(vecs[i].exp_wren));
            if (vecs[i].exp_wren)
                chk($sformatf("vec%0d_addr_data", i), {14'd0, ram_addr, ram_data},
                    32'({15'(vecs[i].exp_addr), 3'(vecs[i].col)}));
            @(posedge clock); #1;
`ifdef PIXSINK_CHECKSUM_EN
            cs_exp = vecs[i].exp_cs;
`else
            cs_exp = 16'h0000;
`endif
            chk($sformatf("vec%0d_pix_count", i), 32'(pix_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_flags", i), {oob_err, seq_err}, {vecs[i].exp_oob, vecs[i].exp_seq});
            chk($sformatf("vec%0d_checksum", i), 32'(checksum), 32'(cs_exp));
        end

        // Out-of-sequence pair.
        pulse_frame_start();
        send(0, 0, 1, waits);
        send(2, 0, 3, waits);
        drain();
        chk("seq_pair_seq_err", 32'(seq_err), 1);
        chk("seq_pair_pix_count", 32'(pix_count), 2);
        check_model("seq_pair");

        // Back-pressure: RAM stalls with two pixels in flight.
        pulse_frame_start();
        ram_ready = 1'b0;
        send(0, 0, 5, waits);
        send(1, 0, 6, waits);
        in_x = 8'd2; in_y = 7'd0; in_col = 3'd7; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 0);
            chk($sformatf("stall%0d_write", c), {13'd0, ram_wren, ram_addr, ram_data}, {13'd0, 1'b1, 15'd0, 3'd5});
            @(posedge clock); #1;
        end
        ram_ready = 1'b1;
        for (int i = 2; i < 20; i++) send(i, 0, i % 8, waits);
        drain();
        chk("bp_pix_count", 32'(pix_count), 20);
        chk("bp_seq_err", 32'(seq_err), 0);
        check_model("bp");

        // Full raster, back-to-back with ram_ready held high.
        pulse_frame_start();
        total_waits = 0;
        for (int i = 0; i < NPIX; i++) begin
            send(i % W, i / W, i % 8, waits);
            total_waits += waits;
        end
        chk("raster_throughput_waits", 32'(total_waits), 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("raster_frame_done", 32'(frame_done), 1);
        chk("raster_pix_count", 32'(pix_count), NPIX);
        chk("raster_errs", {oob_err, seq_err}, 0);
        chk("raster_in_ready_done", 32'(in_ready), 0);
        check_model("raster");

        // frame_start collides with an offered pixel after 100 pixels.
        pulse_frame_start();
        for (int i = 0; i < 100; i++) send(i % W, i / W, i % 8, waits);
        in_x = 8'd100; in_y = 7'd0; in_col = 3'd4; in_valid = 1'b1; frame_start = 1'b1;
        @(negedge clock);
        chk("fs_in_ready", 32'(in_ready), 0);
        @(posedge clock); #1;
        frame_start = 1'b0; in_valid = 1'b0;
        chk("fs_cleared", {pix_count, checksum, frame_done, oob_err, seq_err, ram_wren}, '0);
        rand_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) send(i % W, i / W, $urandom_range(0, 7), waits);
        drain();
        chk("fs_raster_done", {frame_done, pix_count}, {1'b1, 15'(NPIX)});
        check_model("fs_raster");

        // Randomized coordinates (some out of bounds) with random RAM back-pressure.
        pulse_frame_start();
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                send($urandom_range(0, 169), $urandom_range(0, 125), $urandom_range(0, 7), waits);
            else
                send(i % W, i / W, $urandom_range(0, 7), waits);
        end
        drain();
        check_model("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
